// File: rtl/matmul_engine.sv
// N x N unsigned matrix multiply: streams A and B from RAM, then computes one C element per cycle; done after 2N+2+N(N+1) cycles.
// No backpressure: RAM reads and writes are fire-and-forget; comp_enb is ignored while busy.
module matmul_engine #(
  parameter int N  = 4,
  parameter int EW = 16,
  parameter int AW = 16,
  parameter int DW = N * EW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          comp_enb,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] res_base,
  input  logic          b_trans,
  input  logic          sat_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          mem_read_enb,
  output logic          mem_write_enb,
  output logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_data,
  output logic          busyb,
  output logic          done
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(2 * N + 2);
  localparam int PW = 2 * EW;
  localparam int SW = 2 * EW + $clog2(N);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_WRITE, S_DONE} state_t;

  state_t                      r_state;
  logic [CW-1:0]               r_cnt;
  logic [IW-1:0]               r_i;
  logic [IW-1:0]               r_j;
  logic [AW-1:0]               r_a_base;
  logic [AW-1:0]               r_b_base;
  logic [AW-1:0]               r_res_base;
  logic                        r_b_trans;
  logic                        r_sat_en;
  logic [N-1:0][N-1:0][EW-1:0] r_a;
  logic [N-1:0][N-1:0][EW-1:0] r_b;
  logic [N-1:0][EW-1:0]        r_row;
  logic [AW-1:0]               r_mem_addr;
  logic [AW-1:0]               r_res_addr;
  logic                        r_rd;
  logic                        r_wr;
  logic                        r_busyb;
  logic                        r_done;

  logic [CW-1:0]        w_nc;
  logic [CW-1:0]        w_cm1;
  logic [IW-1:0]        w_bidx;
  logic [N-1:0][PW-1:0] w_prod;
  logic [N:0][SW-1:0]   w_acc;
  logic [SW-1:0]        w_sum;
  logic [EW-1:0]        w_elem;

  assign w_nc   = r_cnt + CW'(1);
  assign w_cm1  = r_cnt - CW'(1);
  assign w_bidx = w_cm1[IW-1:0] - IW'(N);

  // Column j of B is either element j of every word, or every element of word j.
  assign w_acc[0] = '0;
  for (genvar k = 0; k < N; k++) begin : g_dot
    assign w_prod[k]  = PW'(r_a[r_i][k]) * PW'(r_b_trans ? r_b[r_j][k] : r_b[k][r_j]);
    assign w_acc[k+1] = w_acc[k] + SW'(w_prod[k]);
  end

  assign w_sum  = w_acc[N];
  assign w_elem = (r_sat_en && (|w_sum[SW-1:EW])) ? {EW{1'b1}} : w_sum[EW-1:0];

  // LOAD cycle c captures the word requested in cycle c-1.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && r_cnt != '0) begin
      if (w_cm1 < CW'(N)) r_a[w_cm1[IW-1:0]] <= mem_data;
      else                r_b[w_bidx]        <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_a_base   <= '0;
      r_b_base   <= '0;
      r_res_base <= '0;
      r_b_trans  <= 1'b0;
      r_sat_en   <= 1'b0;
      r_row      <= '0;
      r_mem_addr <= '0;
      r_res_addr <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_busyb    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (comp_enb) begin
            r_a_base   <= a_base;
            r_b_base   <= b_base;
            r_res_base <= res_base;
            r_b_trans  <= b_trans;
            r_sat_en   <= sat_en;
            r_mem_addr <= a_base;
            r_rd       <= 1'b1;
            r_busyb    <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt <= w_nc;
          if (w_nc < CW'(N)) begin
            r_rd       <= 1'b1;
            r_mem_addr <= r_a_base + AW'(w_nc);
          end else if (w_nc < CW'(2 * N)) begin
            r_rd       <= 1'b1;
            r_mem_addr <= r_b_base + AW'(w_nc - CW'(N));
          end else begin
            r_rd <= 1'b0;
          end
          if (r_cnt == CW'(2 * N)) begin
            r_i     <= '0;
            r_j     <= '0;
            r_state <= S_COMP;
          end
        end
        S_COMP: begin
          r_row[r_j] <= w_elem;
          if (r_j == IW'(N - 1)) begin
            r_wr       <= 1'b1;
            r_res_addr <= r_res_base + AW'(r_i);
            r_state    <= S_WRITE;
          end else begin
            r_j <= r_j + IW'(1);
          end
        end
        S_WRITE: begin
          r_wr <= 1'b0;
          if (r_i == IW'(N - 1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_i     <= r_i + IW'(1);
            r_j     <= '0;
            r_state <= S_COMP;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busyb <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr      = r_mem_addr;
  assign mem_read_enb  = r_rd;
  assign mem_write_enb = r_wr;
  assign res_addr      = r_res_addr;
  assign res_data      = r_row;
  assign busyb         = r_busyb;
  assign done          = r_done;

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised N×N matrix-multiply engine that replaces the fixed-size accelerator under the existing memory testbench. On a one-cycle `comp_enb` pulse it streams matrix A and matrix B from the input RAM, computes C = A·B one element per cycle, and writes C row by row into the result RAM. It adds four things the fixed block lacks: base-address inputs, an optional transposed-B layout, optional saturation, and a proper reset.

## Interface
Parameters:
- N, 4: matrix dimension (N ≥ 2).
- EW, 16: element width in bits, unsigned.
- AW, 16: memory address width.
- DW, N*EW: memory word width; one word holds one matrix row, element 0 in bits [EW-1:0].

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- comp_enb  in  1  start pulse; sampled only in IDLE.
- a_base  in  AW  address of A row 0; A row r is at a_base+r.
- b_base  in  AW  address of B word 0; B word k is at b_base+k.
- res_base  in  AW  address of C row 0 in the result RAM.
- b_trans  in  1  0: B word k is row k of B. 1: B word k is column k of B.
- sat_en  in  1  1: saturate each C element to 2^EW−1. 0: keep the low EW bits.
- mem_addr  out  AW  input-RAM read address.
- mem_data  in  DW  input-RAM read data; valid one cycle after the address with mem_read_enb.
- mem_read_enb  out  1  input-RAM read strobe, active high.
- mem_write_enb  out  1  result-RAM write strobe, active high, one cycle per row.
- res_addr  out  AW  result-RAM write address.
- res_data  out  DW  result-RAM write data, packed like the input rows.
- busyb  out  1  active-low busy; 0 from LOAD through WRITE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE → LOAD → COMP ⇄ WRITE → DONE → IDLE.
- IDLE:
  - busyb=1.
  - If comp_enb=1, latch a_base, b_base, res_base, b_trans and sat_en, then go to LOAD.
- LOAD, 2N+1 cycles:
  - Cycles 0..2N−1: mem_read_enb=1 and mem_addr = a_base+0..N−1, then b_base+0..N−1.
  - Data returning one cycle later goes into the A[0..N−1] and B[0..N−1] register banks.
  - The final cycle only captures data; mem_read_enb=0.
- COMP, one cycle per element C[i][j], with i and j starting at 0:
  - C[i][j] = Σk A[i][k]·Bcol_j[k].
  - When b_trans=0, Bcol_j[k] = element j of B word k. When b_trans=1, Bcol_j[k] = element k of B word j.
  - Each product is EW×EW→2EW. The accumulator is 2EW+⌈log2 N⌉ bits, so it never overflows.
  - Stored element: if sat_en=1, min(sum, 2^EW−1); otherwise sum[EW−1:0].
  - The element is written into slot j of a row buffer.
  - After j=N−1, go to WRITE.
- WRITE, one cycle:
  - mem_write_enb=1, res_addr=res_base+i, res_data=row buffer.
  - If i<N−1: i++, j=0, back to COMP. Otherwise go to DONE.
- DONE, one cycle: done=1 and busyb still 0, then IDLE with busyb=1.
- Address arithmetic is modulo 2^AW; a base near 2^AW−1 wraps to 0.
- comp_enb outside IDLE is ignored. Changes to the base, b_trans and sat_en inputs after the start are ignored.

## Timing
- Reset values: all outputs 0 except busyb=1. State IDLE, counters 0.
- rst at any time forces the reset values on the same edge, not waiting for the clock.
  - No write strobe may appear after rst rises.
  - A new start is accepted on the first edge after rst falls.
- Call the edge that samples comp_enb edge 0.
  - LOAD occupies edges 0..2N+1.
  - COMP/WRITE occupy N(N+1) cycles.
  - done is high during the cycle after edge 2N+1+N(N+1); for N=4 that is edge 29.
  - busyb=1 again after edge 2N+2+N(N+1).
- Row i is written after edge 2N+1+(i+1)(N+1)−1.
- Outputs are registered; no combinational path from inputs to outputs.
- Back-to-back: comp_enb held high through DONE starts a new run on the first IDLE edge.

## Test plan
- Identity: A = I at a_base=0, B rows {1,2,3,4}…{13,14,15,16} at b_base=4, b_trans=0, res_base=0.
  - Result RAM 0..3 equals the B rows.
  - done at edge 29.
  - Exactly 4 write strobes.
- Transpose mode: same data with b_trans=1 and A = I.
  - Result row i has element j = element i of B word j, i.e. Bᵀ.
- Saturation: all A and B elements 0xFFFF.
  - sat_en=1: every C element is 0xFFFF.
  - sat_en=0: every C element is (4·0xFFFE0001)[15:0] = 0x0004.
- Wrap-around: a_base=0xFFFE.
  - Reads go to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - res_base=0xFFFF writes rows to 0xFFFF, 0x0000, 0x0001, 0x0002.
- Reset mid-run: assert rst at edge 15.
  - Immediately: busyb=1, done=0, mem_write_enb=0.
  - No further writes occur.
  - A restart after release produces the correct full result.
- Ignored start: pulse comp_enb at edge 10 during a run.
  - No second run; done pulses exactly once.
